// File: rtl/depthwise_mac3x3.sv
// depthwise_mac3x3
// ----------------
// Depthwise 3x3 convolution MAC. Each accepted 3x3 window is multiplied by a
// 9-tap signed kernel, summed, biased, rounded/shifted by SHIFT and clamped to
// an unsigned DATA_W pixel. The kernel and bias are loaded serially into a
// shadow set and committed atomically into the active set, so windows already
// in flight always finish with the coefficients they were accepted with.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid        window strobe (no backpressure)
//   in_window       9 taps, tap k at bits [(8-k)*DATA_W +: DATA_W]
//   in_ready        high once an active coefficient set exists
//   wt_load_start   pulse, begins (or restarts) a coefficient load
//   wt_valid        coefficient word strobe
//   wt_data         words 0..8 = weights [WT_W-1:0], word 9 = bias [BIAS_W-1:0]
//   wt_busy         high while a load is in progress
//   out_valid       result strobe, 4 cycles after window acceptance
//   out_pixel       result pixel, holds its value between results
//   drop_cnt        windows dropped for lack of coefficients (saturating)

module depthwise_mac3x3 #(
   parameter int DATA_W = 8,
   parameter int WT_W   = 8,
   parameter int BIAS_W = 16,
   parameter int ACC_W  = 24,
   parameter int SHIFT  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [9*DATA_W-1:0]   in_window,
   output logic                  in_ready,
   input  logic                  wt_load_start,
   input  logic                  wt_valid,
   input  logic [15:0]           wt_data,
   output logic                  wt_busy,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_pixel,
   output logic [15:0]           drop_cnt
);

   localparam int PROD_W = DATA_W + WT_W + 1;

   // Rounding offset 2^(SHIFT-1); collapses to zero when SHIFT is zero.
   localparam logic signed [ACC_W-1:0] RND     = ACC_W'((1 << SHIFT) >> 1);
   localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

   typedef enum logic {IDLE, LOAD} state_t;

   state_t state, state_nxt;
   logic [3:0] idx, idx_nxt;
   logic shadow_we;
   logic commit;

   logic signed [WT_W-1:0]   sh_w  [9];
   logic signed [WT_W-1:0]   act_w [9];
   logic signed [BIAS_W-1:0] sh_b;
   logic signed [BIAS_W-1:0] act_b;
   logic                     act_valid;

   logic [DATA_W-1:0]        tap  [9];
   logic signed [PROD_W-1:0] prod [9];

   logic                     s1_v;
   logic signed [PROD_W-1:0] s1_p [9];
   logic signed [BIAS_W-1:0] s1_b;

   logic                     s2_v;
   logic signed [ACC_W-1:0]  s2_r0, s2_r1, s2_r2;
   logic signed [BIAS_W-1:0] s2_b;

   logic                     s3_v;
   logic signed [ACC_W-1:0]  s3_acc;

   logic signed [ACC_W-1:0]  shifted;
   logic [DATA_W-1:0]        clamped;

   logic accept;

   // ---------------------------------------------------------------------
   // Coefficient load FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // A start pulse always wins over a simultaneous word, so the word is lost
   // and the index restarts at zero. The tenth word is the bias and commits.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      shadow_we = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (wt_load_start) begin
               state_nxt = LOAD;
               idx_nxt   = '0;
            end
         end
         LOAD: begin
            if (wt_load_start) begin
               idx_nxt = '0;
            end else if (wt_valid) begin
               if (idx == 4'd9) begin
                  commit    = 1'b1;
                  state_nxt = IDLE;
                  idx_nxt   = '0;
               end else begin
                  shadow_we = 1'b1;
                  idx_nxt   = idx + 4'd1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   assign wt_busy  = (state == LOAD);
   assign in_ready = act_valid;

   // The bias word goes straight into the active set on the commit edge,
   // since the shadow bias register only receives it on that same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 9; k++) begin
            sh_w[k]  <= '0;
            act_w[k] <= '0;
         end
         sh_b      <= '0;
         act_b     <= '0;
         act_valid <= 1'b0;
      end else begin
         if (shadow_we) begin
            sh_w[idx] <= wt_data[WT_W-1:0];
         end
         if (commit) begin
            sh_b      <= wt_data[BIAS_W-1:0];
            act_w     <= sh_w;
            act_b     <= wt_data[BIAS_W-1:0];
            act_valid <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Window acceptance and drop counter
   // ---------------------------------------------------------------------
   assign accept = in_valid && act_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (in_valid && !act_valid && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // ---------------------------------------------------------------------
   // S1: per-tap products, unsigned tap times signed weight
   // ---------------------------------------------------------------------
   always_comb begin
      for (int k = 0; k < 9; k++) begin
         tap[k]  = in_window[(8-k)*DATA_W +: DATA_W];
         prod[k] = PROD_W'($signed({1'b0, tap[k]})) * PROD_W'(act_w[k]);
      end
   end

   // Pipeline valids are the only pipeline state that needs a reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v      <= 1'b0;
         s2_v      <= 1'b0;
         s3_v      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         s1_v      <= accept;
         s2_v      <= s1_v;
         s3_v      <= s2_v;
         out_valid <= s3_v;
      end
   end

   // The bias travels with its products so a later commit cannot alter a
   // window that is already in the pipeline.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_p <= prod;
         s1_b <= act_b;
      end
   end

   // ---------------------------------------------------------------------
   // S2: row partial sums
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (s1_v) begin
         s2_r0 <= ACC_W'(s1_p[0]) + ACC_W'(s1_p[1]) + ACC_W'(s1_p[2]);
         s2_r1 <= ACC_W'(s1_p[3]) + ACC_W'(s1_p[4]) + ACC_W'(s1_p[5]);
         s2_r2 <= ACC_W'(s1_p[6]) + ACC_W'(s1_p[7]) + ACC_W'(s1_p[8]);
         s2_b  <= s1_b;
      end
   end

   // ---------------------------------------------------------------------
   // S3: final accumulation with bias
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (s2_v) begin
         s3_acc <= s2_r0 + s2_r1 + s2_r2 + ACC_W'(s2_b);
      end
   end

   // ---------------------------------------------------------------------
   // S4: round half up, arithmetic shift, clamp to the pixel range
   // ---------------------------------------------------------------------
   always_comb begin
      shifted = (s3_acc + RND) >>> SHIFT;
      if (shifted[ACC_W-1]) begin
         clamped = '0;
      end else if (shifted > PIX_MAX) begin
         clamped = '1;
      end else begin
         clamped = shifted[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_pixel <= '0;
      end else if (s3_v) begin
         out_pixel <= clamped;
      end
   end

endmodule

// File: tb/tb_depthwise_mac3x3.sv
// Testbench for depthwise_mac3x3. Two instances share all inputs: one with
// SHIFT=0 and one with SHIFT=2. Expected pixels are pushed to per-instance
// queues when a window is driven and popped when out_valid appears, along
// with the cycle the result is due.

module tb_depthwise_mac3x3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [71:0] in_window = '0;
   logic        wt_load_start = 1'b0;
   logic        wt_valid = 1'b0;
   logic [15:0] wt_data = '0;

   logic        in_ready_s0, wt_busy_s0, out_valid_s0;
   logic [7:0]  out_pixel_s0;
   logic [15:0] drop_cnt_s0;
   logic        in_ready_s2, wt_busy_s2, out_valid_s2;
   logic [7:0]  out_pixel_s2;
   logic [15:0] drop_cnt_s2;

   always #5 clk = ~clk;

   depthwise_mac3x3 #(.SHIFT(0)) dut_s0 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_window(in_window), .in_ready(in_ready_s0),
      .wt_load_start(wt_load_start), .wt_valid(wt_valid), .wt_data(wt_data),
      .wt_busy(wt_busy_s0), .out_valid(out_valid_s0), .out_pixel(out_pixel_s0),
      .drop_cnt(drop_cnt_s0)
   );

   depthwise_mac3x3 #(.SHIFT(2)) dut_s2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_window(in_window), .in_ready(in_ready_s2),
      .wt_load_start(wt_load_start), .wt_valid(wt_valid), .wt_data(wt_data),
      .wt_busy(wt_busy_s2), .out_valid(out_valid_s2), .out_pixel(out_pixel_s2),
      .drop_cnt(drop_cnt_s2)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int pix; int due; } exp_t;
   typedef struct { int kern; int tap_c; int tap_o; int e0; int e2; } vec_t;

   exp_t q0[$];
   exp_t q2[$];

   int checks = 0;
   int passes = 0;
   int exp_drop = 0;

   int   mw [9];
   int   mb = 0;
   logic m_valid = 1'b0;

   int   kern_w [5][9];
   int   kern_b [5];
   vec_t vecs [14];

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   function automatic int model(input logic [71:0] win, input int sh);
      int acc;
      int r;
      acc = mb;
      for (int k = 0; k < 9; k++) acc += int'(win[(8-k)*8 +: 8]) * mw[k];
      r = (sh > 0) ? ((acc + (1 << (sh - 1))) >>> sh) : acc;
      if (r < 0) r = 0;
      if (r > 255) r = 255;
      return r;
   endfunction

   function automatic logic [71:0] centreWin(input int c, input int o);
      logic [71:0] w;
      for (int k = 0; k < 9; k++) w[(8-k)*8 +: 8] = (k == 4) ? 8'(c) : 8'(o);
      return w;
   endfunction

   function automatic logic [71:0] randWin();
      logic [71:0] w;
      for (int k = 0; k < 9; k++) w[(8-k)*8 +: 8] = 8'($urandom_range(0, 40));
      return w;
   endfunction

   // Pops and compares whatever results the two instances produced this cycle.
   task automatic scoreCycle();
      exp_t e;
      if (out_valid_s0) begin
         if (q0.size() == 0) checkOutput("unexpected out_valid s0", out_valid_s0, 0);
         else begin
            e = q0.pop_front();
            checkOutput("pixel s0", out_pixel_s0, e.pix);
            checkOutput("latency s0", cyc, e.due);
         end
      end else if (q0.size() != 0 && q0[0].due <= cyc) begin
         checkOutput("missing out_valid s0", out_valid_s0, 1);
         e = q0.pop_front();
      end
      if (out_valid_s2) begin
         if (q2.size() == 0) checkOutput("unexpected out_valid s2", out_valid_s2, 0);
         else begin
            e = q2.pop_front();
            checkOutput("pixel s2", out_pixel_s2, e.pix);
            checkOutput("latency s2", cyc, e.due);
         end
      end else if (q2.size() != 0 && q2[0].due <= cyc) begin
         checkOutput("missing out_valid s2", out_valid_s2, 1);
         e = q2.pop_front();
      end
   endtask

   // Drives one cycle of inputs starting at a falling edge; accepted windows
   // push their expected pixels, rejected ones bump the expected drop count.
   task automatic applyStimulus(input logic v, input logic [71:0] win, input logic ls,
                                input logic wv, input logic [15:0] wd, input logic acc,
                                input int e0, input int e2);
      in_valid      = v;
      in_window     = win;
      wt_load_start = ls;
      wt_valid      = wv;
      wt_data       = wd;
      if (v) begin
         if (acc) begin
            q0.push_back('{e0, cyc + 4});
            q2.push_back('{e2, cyc + 4});
         end else begin
            exp_drop++;
         end
      end
      @(negedge clk);
      in_valid      = 1'b0;
      wt_load_start = 1'b0;
      wt_valid      = 1'b0;
      scoreCycle();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 0, 0);
   endtask

   task automatic cycleDrive(input logic stream, input logic ls, input logic wv,
                             input logic [15:0] wd);
      logic [71:0] w;
      w = randWin();
      applyStimulus(stream, w, ls, wv, wd, m_valid, model(w, 0), model(w, 2));
   endtask

   task automatic setModel(input int kid);
      for (int k = 0; k < 9; k++) mw[k] = kern_w[kid][k];
      mb      = kern_b[kid];
      m_valid = 1'b1;
   endtask

   task automatic loadKernel(input int kid, input logic stream);
      cycleDrive(stream, 1'b1, 1'b0, '0);
      checkOutput("wt_busy after start", wt_busy_s0, 1);
      for (int i = 0; i < 9; i++) begin
         cycleDrive(stream, 1'b0, 1'b1, 16'(kern_w[kid][i]));
         checkOutput("wt_busy mid-load", wt_busy_s0, 1);
      end
      checkOutput("in_ready before commit", in_ready_s0, int'(m_valid));
      cycleDrive(stream, 1'b0, 1'b1, 16'(kern_b[kid]));
      setModel(kid);
      checkOutput("wt_busy after commit", wt_busy_s0, 0);
      checkOutput("in_ready after commit s0", in_ready_s0, 1);
      checkOutput("in_ready after commit s2", in_ready_s2, 1);
   endtask

   initial begin
      int cur_kern;
      logic [71:0] w7;

      for (int k = 0; k < 9; k++) begin
         kern_w[0][k] = 1;
         kern_w[1][k] = -1;
         kern_w[2][k] = (k == 4) ? 1 : 0;
         kern_w[3][k] = (k == 4) ? 1 : 0;
         kern_w[4][k] = (k == 0) ? 2 : 0;
         mw[k] = 0;
      end
      kern_b[0] = 0;
      kern_b[1] = 0;
      kern_b[2] = 0;
      kern_b[3] = -16;
      kern_b[4] = 5;

      vecs[0]  = '{0,  10,  10,  90,  23};
      vecs[1]  = '{0, 255, 255, 255, 255};
      vecs[2]  = '{0,   0,   1,   8,   2};
      vecs[3]  = '{0, 255,   0, 255,  64};
      vecs[4]  = '{0,   0,  32, 255,  64};
      vecs[5]  = '{1,  50,  50,   0,   0};
      vecs[6]  = '{1,   0,   0,   0,   0};
      vecs[7]  = '{2,   6,   0,   6,   2};
      vecs[8]  = '{2,   5,   0,   5,   1};
      vecs[9]  = '{2,   6, 255,   6,   2};
      vecs[10] = '{3, 200,   0, 184,  46};
      vecs[11] = '{3,  10,   0,   0,   0};
      vecs[12] = '{3,  17,   0,   1,   0};
      vecs[13] = '{3, 255,  99, 239,  60};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset out_valid", out_valid_s0, 0);
      checkOutput("reset out_pixel", out_pixel_s0, 0);
      checkOutput("reset in_ready", in_ready_s0, 0);
      checkOutput("reset wt_busy", wt_busy_s0, 0);
      checkOutput("reset drop_cnt", drop_cnt_s0, 0);
      checkOutput("reset out_valid s2", out_valid_s2, 0);
      reset = 1'b0;

      // Windows before any load are dropped
      for (int i = 0; i < 3; i++) cycleDrive(1'b1, 1'b0, 1'b0, '0);
      checkOutput("drop_cnt s0 after drops", drop_cnt_s0, exp_drop);
      checkOutput("drop_cnt s2 after drops", drop_cnt_s2, 3);
      checkOutput("in_ready before load", in_ready_s0, 0);

      // Words without a start pulse are ignored in IDLE
      for (int i = 0; i < 10; i++) cycleDrive(1'b0, 1'b0, 1'b1, 16'h0001);
      checkOutput("wt_busy idle words", wt_busy_s0, 0);
      checkOutput("in_ready idle words", in_ready_s0, 0);

      // Initial load, then 20 back-to-back windows
      loadKernel(0, 1'b0);
      for (int i = 0; i < 20; i++) cycleDrive(1'b1, 1'b0, 1'b0, '0);

      // Table vectors, reloading kernels as the table moves on
      cur_kern = 0;
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].kern != cur_kern) begin
            loadKernel(vecs[i].kern, 1'b0);
            cur_kern = vecs[i].kern;
         end
         applyStimulus(1'b1, centreWin(vecs[i].tap_c, vecs[i].tap_o), 1'b0, 1'b0, '0,
                       1'b1, vecs[i].e0, vecs[i].e2);
      end
      idleCycles(6);

      // Reload kernel B while streaming with kernel A, with a restart and a
      // start/word collision mid-load
      loadKernel(0, 1'b0);
      cycleDrive(1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 4; i++) cycleDrive(1'b1, 1'b0, 1'b1, 16'h0077);
      cycleDrive(1'b1, 1'b1, 1'b1, 16'h0055);
      checkOutput("wt_busy after restart", wt_busy_s0, 1);
      for (int i = 0; i < 9; i++) begin
         cycleDrive(1'b1, 1'b0, 1'b1, 16'(kern_w[4][i]));
         checkOutput("wt_busy reload", wt_busy_s0, 1);
      end
      cycleDrive(1'b1, 1'b0, 1'b1, 16'(kern_b[4]));
      setModel(4);
      checkOutput("wt_busy reload done", wt_busy_s2, 0);
      w7 = randWin();
      w7[71:64] = 8'd7;
      applyStimulus(1'b1, w7, 1'b0, 1'b0, '0, 1'b1, 19, 5);
      for (int i = 0; i < 4; i++) cycleDrive(1'b1, 1'b0, 1'b0, '0);
      idleCycles(6);

      // Reset with windows in flight and a load at index 5
      cycleDrive(1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 5; i++) cycleDrive(i >= 2, 1'b0, 1'b1, 16'h0001);
      reset = 1'b1;
      q0.delete();
      q2.delete();
      m_valid  = 1'b0;
      exp_drop = 0;
      @(negedge clk);
      reset = 1'b0;
      idleCycles(6);
      checkOutput("post-reset in_ready", in_ready_s0, 0);
      checkOutput("post-reset wt_busy", wt_busy_s0, 0);
      checkOutput("post-reset drop_cnt", drop_cnt_s0, 0);
      checkOutput("post-reset out_valid", out_valid_s0, 0);
      cycleDrive(1'b1, 1'b0, 1'b0, '0);
      checkOutput("post-reset drop s0", drop_cnt_s0, exp_drop);
      checkOutput("post-reset drop s2", drop_cnt_s2, 1);
      idleCycles(6);

      checkOutput("scoreboard s0 drained", q0.size(), 0);
      checkOutput("scoreboard s2 drained", q2.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/depthwise_mac3x3.md
Name: depthwise_mac3x3

Overview:
Consumes 3x3 pixel windows from the line-buffer window generator and computes one depthwise-convolution output pixel per window. Each window is multiplied by a 9-tap signed kernel and summed, then a bias is added. The result is rounded, shifted and clamped to an unsigned pixel. The kernel and bias are loaded serially into a shadow set and committed atomically, so a reload never corrupts windows already in flight. The output feeds the pointwise/activation stage.

Parameters:
DATA_W, 8, pixel width (unsigned), input taps and output pixel.
WT_W, 8, kernel weight width (signed two's complement).
BIAS_W, 16, bias width (signed).
ACC_W, 24, internal accumulator width (signed); must hold 9*(2^DATA_W-1)*2^(WT_W-1) plus bias.
SHIFT, 0, requantisation right-shift amount (0..ACC_W-2).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  window strobe.
in_window  in  9*DATA_W  3x3 window; tap k (k=0 top-left, row-major, k=8 bottom-right) at bits [(8-k)*DATA_W +: DATA_W].
in_ready  out  1  high once an active coefficient set exists; informational only, no backpressure.
wt_load_start  in  1  pulse; begins a new coefficient load.
wt_valid  in  1  coefficient word strobe.
wt_data  in  16  coefficient word; words 0..8 use [WT_W-1:0] as weight k, word 9 uses [BIAS_W-1:0] as bias.
wt_busy  out  1  high while in LOAD state.
out_valid  out  1  result strobe.
out_pixel  out  DATA_W  result pixel.
drop_cnt  out  16  count of windows discarded for lack of coefficients, saturating at 0xFFFF.

Behaviour:
- Reset (synchronous, active-high; clock clk): out_valid=0, out_pixel=0, in_ready=0, wt_busy=0, drop_cnt=0. FSM goes to IDLE, load index=0. All pipeline valids are cleared. Active and shadow weights and bias are cleared, and the active set is marked invalid.
- Reset asserted mid-load or mid-stream discards everything. No out_valid is produced for windows accepted before reset.
- Load FSM, two states:
  - IDLE: wt_valid is ignored. wt_load_start -> LOAD, index=0.
  - LOAD: each wt_valid writes shadow[index] and increments index. At index 9, wt_valid writes the shadow bias, then on the same edge copies the shadow weights and bias into the active set, sets the active-valid flag and returns to IDLE.
  - wt_load_start in LOAD restarts at index 0; shadow contents are stale but are overwritten.
  - wt_load_start and wt_valid in the same cycle: start wins and the word is ignored.
- wt_busy = (state==LOAD), registered.
- in_ready = active-valid flag; it stays high through later reloads because the old set remains active until commit.
- Window acceptance:
  - in_valid with active set valid: the window enters the pipeline.
  - in_valid with active set invalid: the window is dropped and drop_cnt increments (saturating).
- Commit timing: a commit is visible to a window sampled on the cycle after the commit edge. A window sampled on the same edge uses the old set.
- Pipeline: 4 stages; out_valid asserts exactly 4 cycles after the accepting in_valid edge. Full throughput, one window per cycle, back-to-back, with no bubbles required.
  - S1: p_k = zero-extend(tap_k) * sign-extend(w_k), signed, DATA_W+WT_W+1 bits. Weights and bias are captured alongside, so a later commit does not affect in-flight data.
  - S2: three row partial sums (p0+p1+p2, p3+p4+p5, p6+p7+p8), ACC_W signed.
  - S3: acc = row0+row1+row2+sign-extend(bias), ACC_W signed.
  - S4 shift: if SHIFT>0, r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic shift); else r = acc.
  - S4 clamp: r<0 -> 0; r>2^DATA_W-1 -> 2^DATA_W-1; else r[DATA_W-1:0]. The result is registered to out_pixel with out_valid=1.
- out_valid is 0 in any cycle with no result. out_pixel holds its last value when out_valid=0.
- No wrap or overflow inside ACC_W is permitted with default parameters (max |sum| < 2^19).

Test Plan:
- Load 9 weights=1, bias=0 (SHIFT=0); send window all taps 10 -> out_valid 4 cycles later, out_pixel=90. in_ready=1 from the cycle after the 10th wt_valid.
- Same kernel; send window all taps 255 -> 2295 clamps to out_pixel=255. Then weights all -1 with window all 50 -> -450 clamps to 0.
- Instance with SHIFT=2; weights w4=1, others 0, bias=0. Window with centre tap 6 -> (6+2)>>2 = 2. Centre tap 5 -> 1. Bias=-16 with centre 200 -> (184+2)>>2 = 46.
- Send 3 windows before any load -> no out_valid, drop_cnt=3, in_ready=0. Then load and stream 20 back-to-back windows -> 20 consecutive out_valid pulses with matching golden values.
- Streaming with kernel A (all 1) while reloading kernel B (w0=2, others 0, bias=5): windows sampled up to and including the commit edge use A; the first window after uses B (tap0=7 -> 19). wt_busy=1 for the whole load. wt_load_start mid-load restarts the index.
- Assert reset for 1 cycle with 3 windows in flight and a load at index 5 -> no out_valid afterwards, in_ready=0, wt_busy=0, drop_cnt=0. A subsequent in_valid is dropped (drop_cnt=1).
